// File: rtl/key_round_gen_if.sv
`default_nettype none
// ============================================================================
// key_round_gen_if : round-key request / emission handshake bundle
// Rev 1.0
// ============================================================================
interface key_round_gen_if #(
   parameter int HALF_W = 56
);
   logic                  start;
   logic                  mode;
   logic [HALF_W-1:0]     c_in;
   logic [HALF_W-1:0]     d_in;
   logic                  abort;
   logic                  k_ready;
   logic                  k_valid;
   logic [2*HALF_W-1:0]   k_out;
   logic [3:0]            round;
   logic                  busy;
   logic                  done;

   modport master (
      output start, mode, c_in, d_in, abort, k_ready,
      input  k_valid, k_out, round, busy, done
   );

   modport slave (
      input  start, mode, c_in, d_in, abort, k_ready,
      output k_valid, k_out, round, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/key_round_gen.sv
`default_nettype none
// ============================================================================
// key_round_gen : DES-style C/D round-key generator, encrypt or decrypt order
// Rev 1.0
// ============================================================================
module key_round_gen #(
   parameter int HALF_W = 56
) (
   input  wire logic      clk_i,
   input  wire logic      rst_n_i,
   key_round_gen_if.slave kif
);

   localparam int c_HALF_ROT = 28;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [HALF_W-1:0]   c_q, c_d;
   logic [HALF_W-1:0]   d_q, d_d;
   logic [3:0]          round_q, round_d;
   logic                mode_q, mode_d;
   logic                done_q, done_d;
   logic [1:0]          enc_sh, dec_sh;

   // Shift amount s(idx) for schedule positions 1..16.
   function automatic logic [1:0] shift_amt(input logic [4:0] idx);
      case (idx)
         5'd1, 5'd2, 5'd9, 5'd16: shift_amt = 2'd1;
         default:                 shift_amt = 2'd2;
      endcase
   endfunction

   function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic [1:0] n);
      if (n == 2'd1) rotl = {x[HALF_W-2:0], x[HALF_W-1]};
      else           rotl = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
   endfunction

   function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic [1:0] n);
      if (n == 2'd1) rotr = {x[0], x[HALF_W-1:1]};
      else           rotr = {x[1:0], x[HALF_W-1:2]};
   endfunction

   // Decrypt starts from the fully rotated key (sum of schedule = 28).
   function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] x);
      rotl_half = {x[HALF_W-c_HALF_ROT-1:0], x[HALF_W-1:HALF_W-c_HALF_ROT]};
   endfunction

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      round_d = round_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      enc_sh  = shift_amt(5'(round_q) + 5'd2);
      dec_sh  = shift_amt(5'd16 - 5'(round_q));

      case (state_q)
         ST_IDLE: begin
            if (kif.start) begin
               mode_d  = kif.mode;
               round_d = 4'd0;
               state_d = ST_EMIT;
               if (kif.mode) begin
                  c_d = rotl_half(kif.c_in);
                  d_d = rotl_half(kif.d_in);
               end else begin
                  c_d = rotl(kif.c_in, 2'd1);
                  d_d = rotl(kif.d_in, 2'd1);
               end
            end
         end
         ST_EMIT: begin
            if (kif.abort) begin
               state_d = ST_IDLE;
               round_d = 4'd0;
            end else if (kif.k_ready) begin
               if (round_q == 4'd15) begin
                  state_d = ST_IDLE;
                  round_d = 4'd0;
                  done_d  = 1'b1;
               end else begin
                  round_d = round_q + 4'd1;
                  if (mode_q) begin
                     c_d = rotr(c_q, dec_sh);
                     d_d = rotr(d_q, dec_sh);
                  end else begin
                     c_d = rotl(c_q, enc_sh);
                     d_d = rotl(d_q, enc_sh);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= 4'd0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign kif.k_valid = (state_q == ST_EMIT);
   assign kif.busy    = (state_q == ST_EMIT);
   assign kif.k_out   = {c_q, d_q};
   assign kif.round   = round_q;
   assign kif.done    = done_q;

endmodule
`default_nettype wire

// File: doc/key_round_gen.md
KEY_ROUND_GEN -- requirements
Module: key_round_gen

Interface
REQ-001 SHALL have parameter HALF_W, default 56, giving the width of each key half (C, D); the rotation schedule is fixed for HALF_W=56.
REQ-002 SHALL have CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have START  input  1  request to load a new key and begin generation; sampled only in IDLE.
REQ-005 SHALL have MODE  input  1  sampled with START: 0 = encrypt order, 1 = decrypt order.
REQ-006 SHALL have C_in  input  56  permuted-choice-1 left half.
REQ-007 SHALL have D_in  input  56  permuted-choice-1 right half.
REQ-008 SHALL have ABORT  input  1  cancels generation when in EMIT.
REQ-009 SHALL have K_READY  input  1  downstream accepts K_out this cycle.
REQ-010 SHALL have K_VALID  output  1  K_out holds a valid round key.
REQ-011 SHALL have K_out  output  112  {C_r, D_r} for the current round, registered (PC-2 applied downstream).
REQ-012 SHALL have ROUND  output  4  index 0..15 of the key on K_out, in emission order.
REQ-013 SHALL have BUSY  output  1  high whenever state is EMIT.
REQ-014 SHALL have DONE  output  1  one-cycle pulse after the 16th key is accepted.

Function
REQ-015 SHALL use rotation schedule s1..s16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28), applied identically to C and D.
REQ-016 SHALL implement states IDLE and EMIT only.
REQ-017 In IDLE with START=1: encrypt loads C=rotl(C_in,s1), D=rotl(D_in,s1); decrypt loads C=rotl(C_in,28), D=rotl(D_in,28); ROUND<=0; next state EMIT.
REQ-018 In EMIT, K_VALID SHALL be 1 and K_out SHALL equal {C,D} registers; first key valid the cycle after START.
REQ-019 Handshake: transfer occurs on a cycle with K_VALID=1 and K_READY=1; K_out and ROUND SHALL hold stable while K_VALID=1 and K_READY=0.
REQ-020 On transfer with ROUND<15: ROUND<=ROUND+1; encrypt rotates left by s(ROUND+2); decrypt rotates right by s(16-ROUND); K_VALID stays 1 (one key per cycle at full throughput).
REQ-021 On transfer with ROUND=15: next state IDLE, K_VALID<=0, DONE<=1 for exactly one cycle.
REQ-022 Decrypt round j key SHALL equal encrypt round 15-j key for identical inputs.
REQ-023 ABORT=1 in EMIT SHALL override any transfer: next state IDLE, K_VALID<=0, ROUND<=0, DONE stays 0.
REQ-024 START SHALL be ignored while in EMIT, including the cycle DONE is generated; START in the cycle after DONE is accepted.
REQ-025 ABORT in IDLE SHALL have no effect; START and ABORT together in IDLE SHALL start generation.
REQ-026 All rotations SHALL be modulo 56 bit positions with wrap-around (bit 55 to bit 0 for left).

Reset
REQ-027 RST_N low SHALL immediately force state IDLE, K_VALID=0, DONE=0, ROUND=0, K_out=0, BUSY=0, independent of CLK.
REQ-028 Reset asserted mid-generation SHALL discard the key in progress; no DONE is produced.
REQ-029 After RST_N deasserts, the block SHALL accept START on the first rising edge.

Verification
REQ-030 Encrypt, C_in=56'h1, D_in=56'h80_0000_0000_0000, K_READY=1 -> ROUND 0..15 in 16 consecutive cycles; round0 C=56'h2, D=56'h1; round2 C=56'h10; round15 C=56'h1000_0000; DONE one cycle later.
REQ-031 Decrypt, same inputs -> round0 C=56'h1000_0000, round15 C=56'h2; every round j equals encrypt round 15-j.
REQ-032 Backpressure: K_READY=0 for 3 cycles at ROUND=5 -> K_out, ROUND frozen, K_VALID=1; resumes at ROUND=6 after release; total 16 transfers.
REQ-033 ABORT at ROUND=7 -> K_VALID=0 next cycle, no DONE, BUSY=0; subsequent START restarts at ROUND=0.
REQ-034 RST_N pulsed low at ROUND=10 -> outputs zero asynchronously, no DONE; START pulse during EMIT -> ignored, sequence unchanged.
